// File: rtl/im_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : im_pkg
//  Description : Shared types and constants for the IM instruction-fetch unit.
//                - IM_ADDRWIDTH / IM_DATAWIDTH : IM word-address / data widths
//                - fetch_entry_t               : {pc, inst} queued per fetch
//                - fetch_state_t               : IDLE / RUN issue states
//  Revision    : 1.0 - initial release
// ============================================================================
package im_pkg;

    localparam int IM_ADDRWIDTH = 16;
    localparam int IM_DATAWIDTH = 32;

    typedef struct packed {
        logic [IM_ADDRWIDTH-1:0] pc;
        logic [IM_DATAWIDTH-1:0] inst;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/im_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : im_fetch_fifo
//  Description : Two-entry synchronous FIFO of fetch_entry_t.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                push, push_data - enqueue an entry
//                pop           - dequeue the head entry
//                flush         - empty the queue (wins over push/pop)
//                count         - number of valid entries (0..2)
//                head          - oldest entry (meaningful when count != 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module im_fetch_fifo
    import im_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    // Guard against under/overflow; a push into a full queue is only legal
    // when the head leaves in the same cycle.
    assign w_do_pop  = pop && (r_count != 2'd0);
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/im_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : im_fetch_unit
//  Description : Instruction-fetch initiator for the IM instruction memory.
//                Sequences a word PC, issues IM reads, captures the data one
//                cycle later into a 2-entry queue and presents it to decode
//                over a valid/ready handshake. Handles redirects and
//                decode back-pressure.
//  Ports       : clk, rst                    - clock, sync active-high reset
//                fetch_en                    - fetching permitted
//                redirect_valid, redirect_pc - flush and restart
//                IM_enable, IM_write, IM_address, IM_in - IM request port
//                IM_out                      - IM read data (1-cycle latency)
//                inst_valid, inst_ready, inst_data, inst_pc - decode port
//  Revision    : 1.0 - initial release
// ============================================================================
module im_fetch_unit
    import im_pkg::*;
#(
    parameter int                   ADDRWIDTH = IM_ADDRWIDTH,
    parameter int                   DATAWIDTH = IM_DATAWIDTH,
    parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic                 redirect_valid,
    input  logic [ADDRWIDTH-1:0] redirect_pc,
    output logic                 IM_enable,
    output logic                 IM_write,
    output logic [ADDRWIDTH-1:0] IM_address,
    output logic [DATAWIDTH-1:0] IM_in,
    input  logic [DATAWIDTH-1:0] IM_out,
    output logic                 inst_valid,
    input  logic                 inst_ready,
    output logic [DATAWIDTH-1:0] inst_data,
    output logic [ADDRWIDTH-1:0] inst_pc
);

    fetch_state_t         r_state;
    fetch_state_t         w_state_next;
    logic [ADDRWIDTH-1:0] r_pc;
    logic                 r_inflight;
    logic [ADDRWIDTH-1:0] r_inflight_pc;

    logic [1:0]           w_count;
    fetch_entry_t         w_head;
    fetch_entry_t         w_push_entry;
    logic                 w_handshake;
    logic                 w_push;
    logic [2:0]           w_occupancy;

    // Entries committed once the pending read lands: queued + in flight,
    // minus the one decode is taking this cycle.
    assign w_handshake = inst_valid && inst_ready;
    assign w_occupancy = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_handshake};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and IM request
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        IM_enable    = 1'b0;
        IM_address   = '0;
        case (r_state)
            IDLE: begin
                if (fetch_en) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (!fetch_en) begin
                    w_state_next = IDLE;
                end
                // A redirect always issues its target, regardless of queue
                // occupancy, because the queue and pending data are dropped.
                if (redirect_valid) begin
                    IM_enable  = 1'b1;
                    IM_address = redirect_pc;
                end else if (w_occupancy < 3'd2) begin
                    IM_enable  = 1'b1;
                    IM_address = r_pc;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // PC and in-flight tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= IM_enable;
            if (IM_enable) begin
                r_inflight_pc <= IM_address;
                r_pc          <= IM_address + ADDRWIDTH'(1);
            end else if (redirect_valid) begin
                r_pc <= redirect_pc;
            end
        end
    end

    // The response landing during a redirect belongs to the abandoned stream.
    assign w_push            = r_inflight && !redirect_valid;
    assign w_push_entry.pc   = r_inflight_pc;
    assign w_push_entry.inst = IM_out;

    im_fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_handshake && !redirect_valid),
        .flush     (redirect_valid),
        .count     (w_count),
        .head      (w_head)
    );

    assign inst_valid = (w_count != 2'd0);
    assign inst_data  = w_head.inst;
    assign inst_pc    = w_head.pc;

    assign IM_write = 1'b0;
    assign IM_in    = '0;

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_im_fetch_unit
//  Description : Self-checking bench for im_fetch_unit. Cycle vectors with
//                hand-computed expectations, a wrap-around instance, and a
//                back-pressure stream checked against an in-order model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_im_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_ready;

    logic        a_IM_enable, a_IM_write, a_inst_valid;
    logic [15:0] a_IM_address, a_inst_pc;
    logic [31:0] a_IM_in, a_IM_out, a_inst_data;

    logic        b_IM_enable, b_IM_write, b_inst_valid;
    logic [15:0] b_IM_address, b_inst_pc;
    logic [31:0] b_IM_in, b_IM_out, b_inst_data;

    int errors = 0;
    int checks = 0;
    int row    = 0;

    always #5 clk = ~clk;

    im_fetch_unit #(.ADDRWIDTH(16), .DATAWIDTH(32), .RESET_PC(16'h0010)) dut_a (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .IM_enable(a_IM_enable), .IM_write(a_IM_write), .IM_address(a_IM_address),
        .IM_in(a_IM_in), .IM_out(a_IM_out),
        .inst_valid(a_inst_valid), .inst_ready(inst_ready),
        .inst_data(a_inst_data), .inst_pc(a_inst_pc)
    );

    im_fetch_unit #(.ADDRWIDTH(16), .DATAWIDTH(32), .RESET_PC(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .IM_enable(b_IM_enable), .IM_write(b_IM_write), .IM_address(b_IM_address),
        .IM_in(b_IM_in), .IM_out(b_IM_out),
        .inst_valid(b_inst_valid), .inst_ready(inst_ready),
        .inst_data(b_inst_data), .inst_pc(b_inst_pc)
    );

    // IM contents: 0x10..0x13 hold 0xA0..0xA3, everything else {C0DE, addr}.
    function automatic logic [31:0] memword(input logic [15:0] a);
        if (a >= 16'h0010 && a <= 16'h0013) return 32'h0000_00A0 + {16'h0, a - 16'h0010};
        return {16'hC0DE, a};
    endfunction

    // Synchronous-read IM; garbage when not enabled so stray captures show.
    always @(posedge clk) begin
        a_IM_out <= a_IM_enable ? memword(a_IM_address) : 32'hDEAD_BEEF;
        b_IM_out <= b_IM_enable ? memword(b_IM_address) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        fe;
        logic        rv;
        logic [15:0] rpc;
        logic        rdy;
        logic        en;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] ipc;
        logic        zero;   // outputs must show their reset values
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic fe, input logic rv, input logic [15:0] rpc,
                       input logic rdy, input logic en, input logic [15:0] addr,
                       input logic vld, input logic [15:0] ipc, input logic zero);
        vec_t v;
        v.rst = r; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.en = en; v.addr = addr; v.vld = vld; v.ipc = ipc; v.zero = zero;
        vq.push_back(v);
    endtask

    logic [15:0] wrap_pc [4];

    initial begin
        logic [15:0] exp_pc;
        logic        stalled;
        logic [15:0] prev_pc;
        logic [31:0] prev_data;
        int          hs;

        wrap_pc[0] = 16'hFFFE; wrap_pc[1] = 16'hFFFF;
        wrap_pc[2] = 16'h0000; wrap_pc[3] = 16'h0001;

        //  rst fe rv rpc      rdy en addr      vld ipc      zero
        add(0, 1, 0, 16'h0,   1,  0, 16'h0,    0, 16'h0,    1);  // 0 reset state
        add(0, 1, 0, 16'h0,   1,  1, 16'h010,  0, 16'h0,    0);  // 1 first issue
        add(0, 1, 0, 16'h0,   1,  1, 16'h011,  0, 16'h0,    0);  // 2
        add(0, 1, 0, 16'h0,   1,  1, 16'h012,  1, 16'h010,  0);  // 3 first word
        add(0, 1, 0, 16'h0,   1,  1, 16'h013,  1, 16'h011,  0);  // 4
        add(0, 1, 0, 16'h0,   1,  1, 16'h014,  1, 16'h012,  0);  // 5
        add(0, 1, 0, 16'h0,   1,  1, 16'h015,  1, 16'h013,  0);  // 6
        for (int i = 0; i < 6; i++)
            add(0, 1, 0, 16'h0, 0, 0, 16'h0,   1, 16'h014,  0);  // 7-12 back-pressure
        add(0, 1, 0, 16'h0,   1,  1, 16'h016,  1, 16'h014,  0);  // 13 resume
        add(0, 1, 0, 16'h0,   1,  1, 16'h017,  1, 16'h015,  0);  // 14
        add(0, 1, 0, 16'h0,   0,  0, 16'h0,    1, 16'h016,  0);  // 15 queue fills
        add(0, 1, 1, 16'h200, 1,  1, 16'h200,  1, 16'h016,  0);  // 16 redirect
        add(0, 1, 0, 16'h0,   1,  1, 16'h201,  0, 16'h0,    0);  // 17
        add(0, 1, 0, 16'h0,   1,  1, 16'h202,  1, 16'h200,  0);  // 18 target word
        add(0, 1, 0, 16'h0,   1,  1, 16'h203,  1, 16'h201,  0);  // 19
        add(0, 0, 0, 16'h0,   1,  1, 16'h204,  1, 16'h202,  0);  // 20 fetch_en drop
        add(0, 0, 0, 16'h0,   1,  0, 16'h0,    1, 16'h203,  0);  // 21
        add(0, 0, 0, 16'h0,   1,  0, 16'h0,    1, 16'h204,  0);  // 22 in-flight word
        add(0, 0, 0, 16'h0,   1,  0, 16'h0,    0, 16'h0,    0);  // 23
        add(0, 1, 0, 16'h0,   1,  0, 16'h0,    0, 16'h0,    0);  // 24 fetch_en rise
        add(0, 1, 0, 16'h0,   1,  1, 16'h205,  0, 16'h0,    0);  // 25
        add(0, 1, 0, 16'h0,   1,  1, 16'h206,  0, 16'h0,    0);  // 26
        add(0, 1, 0, 16'h0,   1,  1, 16'h207,  1, 16'h205,  0);  // 27
        add(0, 1, 1, 16'h300, 1,  1, 16'h300,  1, 16'h206,  0);  // 28 redirect w/ read in flight
        add(0, 1, 0, 16'h0,   1,  1, 16'h301,  0, 16'h0,    0);  // 29
        add(0, 1, 0, 16'h0,   1,  1, 16'h302,  1, 16'h300,  0);  // 30
        add(0, 0, 0, 16'h0,   1,  1, 16'h303,  1, 16'h301,  0);  // 31
        add(0, 0, 1, 16'h400, 1,  0, 16'h0,    1, 16'h302,  0);  // 32 redirect in IDLE
        add(0, 1, 0, 16'h0,   1,  0, 16'h0,    0, 16'h0,    0);  // 33
        add(0, 1, 0, 16'h0,   1,  1, 16'h400,  0, 16'h0,    0);  // 34
        add(0, 1, 0, 16'h0,   1,  1, 16'h401,  0, 16'h0,    0);  // 35
        add(1, 1, 0, 16'h0,   0,  0, 16'h0,    1, 16'h400,  0);  // 36 rst mid-stream
        add(0, 1, 0, 16'h0,   1,  0, 16'h0,    0, 16'h0,    1);  // 37 back to reset
        add(0, 1, 0, 16'h0,   1,  1, 16'h010,  0, 16'h0,    0);  // 38 restart at RESET_PC
        add(0, 1, 0, 16'h0,   1,  1, 16'h011,  0, 16'h0,    0);  // 39
        add(0, 1, 0, 16'h0,   1,  1, 16'h012,  1, 16'h010,  0);  // 40

        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 16'h0; inst_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            row            = i;
            rst            = vq[i].rst;
            fetch_en       = vq[i].fe;
            redirect_valid = vq[i].rv;
            redirect_pc    = vq[i].rpc;
            inst_ready     = vq[i].rdy;
            @(negedge clk);
            chk("IM_enable",  {31'h0, a_IM_enable},  {31'h0, vq[i].en});
            chk("inst_valid", {31'h0, a_inst_valid}, {31'h0, vq[i].vld});
            chk("IM_write",   {31'h0, a_IM_write},   32'h0);
            chk("IM_in",      a_IM_in,               32'h0);
            if (vq[i].en || vq[i].zero)
                chk("IM_address", {16'h0, a_IM_address}, {16'h0, vq[i].addr});
            if (vq[i].vld) begin
                chk("inst_pc",   {16'h0, a_inst_pc}, {16'h0, vq[i].ipc});
                chk("inst_data", a_inst_data,        memword(vq[i].ipc));
            end
            if (vq[i].zero) begin
                chk("inst_pc_rst",   {16'h0, a_inst_pc}, 32'h0);
                chk("inst_data_rst", a_inst_data,        32'h0);
            end
            if (i >= 3 && i <= 6) begin
                chk("wrap_valid", {31'h0, b_inst_valid}, 32'h1);
                chk("wrap_pc",    {16'h0, b_inst_pc},    {16'h0, wrap_pc[i-3]});
                chk("wrap_data",  b_inst_data,           memword(wrap_pc[i-3]));
            end
            @(posedge clk);
            #1;
        end

        // Random back-pressure stream: in-order delivery without loss or
        // duplication, and held outputs while stalled. Row 40 consumed 0x10.
        row       = -1;
        exp_pc    = 16'h0011;
        stalled   = 1'b0;
        prev_pc   = '0;
        prev_data = '0;
        hs        = 0;
        fetch_en  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            inst_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (stalled) begin
                chk("stall_valid", {31'h0, a_inst_valid}, 32'h1);
                chk("stall_pc",    {16'h0, a_inst_pc},    {16'h0, prev_pc});
                chk("stall_data",  a_inst_data,           prev_data);
            end
            if (a_inst_valid && inst_ready) begin
                chk("stream_pc",   {16'h0, a_inst_pc}, {16'h0, exp_pc});
                chk("stream_data", a_inst_data,        memword(exp_pc));
                exp_pc = exp_pc + 16'h1;
                hs++;
            end
            stalled   = a_inst_valid && !inst_ready;
            prev_pc   = a_inst_pc;
            prev_data = a_inst_data;
            @(posedge clk);
            #1;
        end
        checks++;
        if (hs < 80) begin
            errors++;
            $display("FAIL stream_throughput: got %0d handshakes, expected at least 80", hs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/im_fetch_unit.md
# im_fetch_unit

Instruction-fetch initiator for the IM instruction memory. It sequences a word-address PC, drives the IM read port (enable/address, write held low), and captures read data one cycle later. It buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. It sits between IM and the decode stage and absorbs branch redirects and decode back-pressure.

## Interface
- ADDRWIDTH, 16, IM word-address width; PC width
- DATAWIDTH, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_en  in  1  1 = fetching permitted
- redirect_valid  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  ADDRWIDTH  new fetch word address
- IM_enable  out  1  IM access strobe
- IM_write  out  1  constant 0
- IM_address  out  ADDRWIDTH  IM word address
- IM_in  out  DATAWIDTH  constant 0
- IM_out  in  DATAWIDTH  IM read data, valid the cycle after IM_enable
- inst_valid  out  1  inst_data/inst_pc hold a fetched word
- inst_ready  in  1  decode accepts when inst_valid && inst_ready
- inst_data  out  DATAWIDTH  instruction word
- inst_pc  out  ADDRWIDTH  word address of inst_data

## Operation
- States: IDLE (no issue) and RUN (issue allowed). rst -> IDLE. IDLE -> RUN when fetch_en=1. RUN -> IDLE when fetch_en=0. Leaving RUN does not cancel an in-flight read or drop queued entries.
- Issue condition, evaluated each cycle: `issue = RUN && (count + inflight - pop) < 2`.
  - pop = inst_valid && inst_ready.
  - inflight = a read was issued in the previous cycle.
- On issue: IM_enable=1, IM_address=pc, pc <= pc+1 modulo 2^ADDRWIDTH (0xFFFF wraps to 0x0000).
- Capture: when inflight=1, push {pc_of_issue, IM_out} into the queue at the end of that cycle. The queue is a FIFO, depth 2. Head drives inst_valid/inst_data/inst_pc.
- Push and pop in the same cycle: count is unchanged and order is preserved. Count never exceeds 2; the issue rule guarantees this.
- Redirect (redirect_valid=1), priority over everything except rst:
  - Queue cleared.
  - The response arriving this cycle is discarded.
  - pop is ignored.
  - If RUN: IM_enable=1 with IM_address=redirect_pc, then pc <= redirect_pc+1.
  - If IDLE: pc <= redirect_pc, no issue.
- IM_write and IM_in are tied low at all times.

## Timing
- Reset values: IM_enable=0, IM_address=0, IM_write=0, IM_in=0, inst_valid=0, inst_data=0, inst_pc=0, pc=RESET_PC, count=0, inflight=0, state IDLE.
- rst asserted mid-operation: the next edge returns all of the above. Any pending IM response is ignored.
- First fetch: fetch_en rises in cycle t (IDLE -> RUN at edge t). Issue occurs in t+1, capture in t+2, inst_valid in t+3.
- Redirect in cycle t (RUN): new address issued in t, IM_out valid in t+1, inst_valid=1 with inst_pc=redirect_pc in t+2.
- Steady state with inst_ready=1 held: one instruction per cycle, no bubbles.
- inst_ready=0 with a full queue: at most 2 queued entries plus 0 in flight. IM_enable stays 0 until a pop.
- inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0.

## Structure
- Shared package im_pkg holds:
  - constants IM_ADDRWIDTH=16 and IM_DATAWIDTH=32
  - typedef fetch_entry_t {logic [ADDRWIDTH-1:0] pc; logic [DATAWIDTH-1:0] inst;}
  - enum fetch_state_t {IDLE, RUN}
- Sub-module im_fetch_fifo: 2-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, head, and synchronous active-high rst.
- The top level holds the state machine, PC, inflight flag, and issue logic.

## Test plan
- Reset/boot: RESET_PC=0x0010, IM preloaded mem[0x10..0x13]=0xA0..0xA3, fetch_en=1 from cycle 0, inst_ready=1 -> inst_valid first at cycle 3, then inst_pc 0x10,0x11,0x12,0x13 with matching data on consecutive cycles.
- Back-pressure: inst_ready=0 for 6 cycles after the first word -> IM_enable deasserts after queue fills (count=2). No word lost or duplicated after inst_ready=1 resumes.
- Redirect: redirect_valid with redirect_pc=0x0200 while queue holds 0x11,0x12 -> those words are never presented. Next handshake has inst_pc=0x0200 exactly 2 cycles later.
- Wrap: RESET_PC=0xFFFE -> inst_pc sequence 0xFFFE,0xFFFF,0x0000,0x0001.
- fetch_en drop/rise: fetch_en=0 for 4 cycles mid-stream -> in-flight word still delivered, no IM_enable while IDLE, sequence resumes at the next PC without gaps.
- Reset mid-stream: rst pulsed with queue full and a read in flight -> next cycle inst_valid=0 and IM_enable=0. Fetch restarts at RESET_PC.
